// File: rtl/swc_pkg.sv
// Shared switch-core constants and the packet-transfer request record.
package swc_pkg;

    localparam int unsigned c_swc_num_ports       = 11;
    localparam int unsigned c_swc_page_addr_width = 10;
    localparam int unsigned c_wrsw_prio_width     = 3;

    // One completed-packet transfer request as presented by an input block
    typedef struct packed {
        logic [c_swc_page_addr_width-1:0] pageaddr;
        logic [c_swc_num_ports-1:0]       mask;
        logic [c_wrsw_prio_width-1:0]     prio;
    } t_pta_req;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_DONE  = 2'd2
    } t_pta_state;

endpackage

// File: rtl/swc_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module swc_rr_arbiter #(
    parameter int unsigned g_num = 11,
    localparam int unsigned c_idx_w = (g_num > 1) ? $clog2(g_num) : 1
) (
    input  logic [g_num-1:0]   req_i,
    input  logic [c_idx_w-1:0] ptr_i,
    output logic [g_num-1:0]   grant_c,
    output logic [c_idx_w-1:0] grant_idx_c,
    output logic               any_c
);

    // Scan g_num positions starting at ptr_i, keep the first hit
    always_comb begin
        int unsigned  k;
        logic [c_idx_w-1:0] kidx;
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        k           = 0;
        kidx        = '0;
        for (int unsigned off = 0; off < g_num; off++) begin
            k = 32'(ptr_i) + off;
            if (k >= g_num) begin
                k = k - g_num;
            end
            kidx = c_idx_w'(k);
            if (!any_c && req_i[kidx]) begin
                any_c         = 1'b1;
                grant_c[kidx] = 1'b1;
                grant_idx_c   = kidx;
            end
        end
    end

endmodule

// File: rtl/swc_pck_transfer_arbiter.sv
// Collects per-input packet transfer requests, arbitrates round-robin and
// offers the winner to every output in its destination mask.
module swc_pck_transfer_arbiter
    import swc_pkg::*;
#(
    parameter int unsigned g_num_ports       = c_swc_num_ports,
    parameter int unsigned g_page_addr_width = c_swc_page_addr_width,
    parameter int unsigned g_prio_width      = c_wrsw_prio_width
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [g_num_ports-1:0]                 ib_transfer_pck_i,
    input  logic [g_num_ports*g_page_addr_width-1:0] ib_pageaddr_i,
    input  logic [g_num_ports*g_num_ports-1:0]     ib_mask_i,
    input  logic [g_num_ports*g_prio_width-1:0]    ib_prio_i,
    output logic [g_num_ports-1:0]                 ib_transfer_ack_o,
    output logic [g_num_ports-1:0]                 ob_transfer_valid_o,
    output logic [g_page_addr_width-1:0]           ob_pageaddr_o,
    output logic [g_prio_width-1:0]                ob_prio_o,
    input  logic [g_num_ports-1:0]                 ob_transfer_ack_i,
    output logic                                   busy_o
);

    localparam int unsigned N = g_num_ports;
    localparam int unsigned A = g_page_addr_width;
    localparam int unsigned P = g_prio_width;
    localparam int unsigned c_idx_w = (N > 1) ? $clog2(N) : 1;

    t_pta_state state_q, state_d;

    logic [N-1:0]       pending_q, pending_d;
    logic [A-1:0]       hold_pageaddr_q [N];
    logic [A-1:0]       hold_pageaddr_d [N];
    logic [N-1:0]       hold_mask_q     [N];
    logic [N-1:0]       hold_mask_d     [N];
    logic [P-1:0]       hold_prio_q     [N];
    logic [P-1:0]       hold_prio_d     [N];
    logic               err_overrun_q, err_overrun_d;

    logic [c_idx_w-1:0] sel_q, sel_d;
    logic [c_idx_w-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]       out_pend_q, out_pend_d;

    logic [N-1:0]       valid_q, valid_d;
    logic [N-1:0]       ack_q, ack_d;
    logic [A-1:0]       pageaddr_q, pageaddr_d;
    logic [P-1:0]       prio_q, prio_d;
    logic               busy_q, busy_d;

    logic [N-1:0]       arb_grant_c;
    logic [c_idx_w-1:0] arb_idx_c;
    logic               arb_any_c;

    swc_rr_arbiter #(
        .g_num (N)
    ) u_rr_arbiter (
        .req_i       (pending_q),
        .ptr_i       (rr_ptr_q),
        .grant_c     (arb_grant_c),
        .grant_idx_c (arb_idx_c),
        .any_c       (arb_any_c)
    );

    // Per-input capture: a slot freed by this cycle's DONE may be refilled at once
    always_comb begin
        logic release_slot;
        logic overrun;
        pending_d       = pending_q;
        hold_pageaddr_d = hold_pageaddr_q;
        hold_mask_d     = hold_mask_q;
        hold_prio_d     = hold_prio_q;
        overrun         = 1'b0;
        release_slot    = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            release_slot = (state_q == S_DONE) && (sel_q == c_idx_w'(i));
            if (release_slot) begin
                pending_d[i] = 1'b0;
            end
            if (ib_transfer_pck_i[i]) begin
                if (!pending_q[i] || release_slot) begin
                    pending_d[i]       = 1'b1;
                    hold_pageaddr_d[i] = ib_pageaddr_i[i*A +: A];
                    hold_mask_d[i]     = ib_mask_i[i*N +: N];
                    hold_prio_d[i]     = ib_prio_i[i*P +: P];
                end else begin
                    overrun = 1'b1;
                end
            end
        end
        err_overrun_d = err_overrun_q | overrun;
    end

    // Transfer FSM next state and registered output values
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        out_pend_d = out_pend_q;
        pageaddr_d = pageaddr_q;
        prio_d     = prio_q;
        valid_d    = '0;
        ack_d      = '0;
        busy_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arb_any_c) begin
                    sel_d      = arb_idx_c;
                    out_pend_d = hold_mask_q[arb_idx_c];
                    pageaddr_d = hold_pageaddr_q[arb_idx_c];
                    prio_d     = hold_prio_q[arb_idx_c];
                    state_d    = (hold_mask_q[arb_idx_c] == '0) ? S_DONE : S_OFFER;
                end
            end
            S_OFFER: begin
                out_pend_d = out_pend_q & ~ob_transfer_ack_i;
                if (out_pend_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rr_ptr_d = (sel_q == c_idx_w'(N - 1)) ? '0 : sel_q + c_idx_w'(1);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_OFFER) begin
            valid_d = out_pend_d;
        end
        if (state_d == S_DONE) begin
            ack_d[sel_d] = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            pending_q       <= '0;
            hold_pageaddr_q <= '{default: '0};
            hold_mask_q     <= '{default: '0};
            hold_prio_q     <= '{default: '0};
            err_overrun_q   <= 1'b0;
            sel_q           <= '0;
            rr_ptr_q        <= '0;
            out_pend_q      <= '0;
            valid_q         <= '0;
            ack_q           <= '0;
            pageaddr_q      <= '0;
            prio_q          <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            hold_pageaddr_q <= hold_pageaddr_d;
            hold_mask_q     <= hold_mask_d;
            hold_prio_q     <= hold_prio_d;
            err_overrun_q   <= err_overrun_d;
            sel_q           <= sel_d;
            rr_ptr_q        <= rr_ptr_d;
            out_pend_q      <= out_pend_d;
            valid_q         <= valid_d;
            ack_q           <= ack_d;
            pageaddr_q      <= pageaddr_d;
            prio_q          <= prio_d;
            busy_q          <= busy_d;
        end
    end

    assign ib_transfer_ack_o   = ack_q;
    assign ob_transfer_valid_o = valid_q;
    assign ob_pageaddr_o       = pageaddr_q;
    assign ob_prio_o           = prio_q;
    assign busy_o              = busy_q;

endmodule

// File: tb/tb_swc_pck_transfer_arbiter.sv
// Bench for swc_pck_transfer_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level reference model.
module tb_swc_pck_transfer_arbiter;
    import swc_pkg::*;

    localparam int unsigned N = c_swc_num_ports;
    localparam int unsigned A = c_swc_page_addr_width;
    localparam int unsigned P = c_wrsw_prio_width;

    logic           clk;
    logic           rst;
    logic [N-1:0]   ib_pck;
    logic [N*A-1:0] ib_pa;
    logic [N*N-1:0] ib_mask;
    logic [N*P-1:0] ib_prio;
    logic [N-1:0]   ib_ack;
    logic [N-1:0]   ob_valid;
    logic [A-1:0]   ob_pa;
    logic [P-1:0]   ob_prio;
    logic [N-1:0]   ob_ack;
    logic           busy;

    int n_checks;
    int n_fail;

    swc_pck_transfer_arbiter dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .ib_transfer_pck_i   (ib_pck),
        .ib_pageaddr_i       (ib_pa),
        .ib_mask_i           (ib_mask),
        .ib_prio_i           (ib_prio),
        .ib_transfer_ack_o   (ib_ack),
        .ob_transfer_valid_o (ob_valid),
        .ob_pageaddr_o       (ob_pa),
        .ob_prio_o           (ob_prio),
        .ob_transfer_ack_i   (ob_ack),
        .busy_o              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queued request per input and the transfer in flight
    t_pta_req     m_req [N];
    bit           m_pend [N];
    int           m_ptr;
    bit           m_active;    // a transfer has been granted
    bit           m_finish;    // granted transfer is in its acknowledge cycle
    int           m_sel;
    logic [N-1:0] m_left;      // outputs that still have to accept
    logic [A-1:0] m_pa;
    logic [P-1:0] m_prio;
    bit           m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_pend[i] = 1'b0;
            m_req[i]  = '0;
        end
        m_ptr = 0; m_active = 0; m_finish = 0; m_sel = 0;
        m_left = '0; m_pa = '0; m_prio = '0; m_err = 0;
    endtask

    // Advance the model by one clock given the inputs driven this cycle
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if (m_finish) begin
            m_pend[m_sel] = 1'b0;
            m_ptr    = (m_sel + 1) % N;
            m_active = 0;
            m_finish = 0;
        end else if (m_active) begin
            m_left = m_left & ~ob_ack;
            if (m_left == '0) m_finish = 1;
        end else begin
            for (int d = 0; d < int'(N); d++) begin
                int k;
                k = (m_ptr + d) % N;
                if (!m_active && m_pend[k]) begin
                    m_active = 1;
                    m_sel    = k;
                    m_left   = m_req[k].mask;
                    m_pa     = m_req[k].pageaddr;
                    m_prio   = m_req[k].prio;
                    m_finish = (m_left == '0);
                end
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (ib_pck[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i]         = 1'b1;
                    m_req[i].pageaddr = ib_pa[i*A +: A];
                    m_req[i].mask     = ib_mask[i*N +: N];
                    m_req[i].prio     = ib_prio[i*P +: P];
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] e_ack;
        logic [N-1:0] e_valid;
        e_ack   = '0;
        e_valid = '0;
        if (m_active && m_finish) e_ack[m_sel] = 1'b1;
        if (m_active && !m_finish) e_valid = m_left;
        check_eq("valid", 32'(ob_valid), 32'(e_valid));
        check_eq("ib_ack", 32'(ib_ack), 32'(e_ack));
        check_eq("busy", 32'(busy), 32'(m_active));
        check_eq("pageaddr", 32'(ob_pa), 32'(m_pa));
        check_eq("prio", 32'(ob_prio), 32'(m_prio));
        check_eq("err_overrun", 32'(dut.err_overrun_q), 32'(m_err));
    endtask

    // One clock: model follows the driven inputs, DUT is sampled on the falling edge
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        ib_pck = '0;
        ob_ack = '0;
        rst    = 1'b0;
        compare_all();
    endtask

    task automatic post(input int port, input int pa, input int mask, input int prio);
        ib_pck[port]          = 1'b1;
        ib_pa[port*A +: A]    = A'(pa);
        ib_mask[port*N +: N]  = N'(mask);
        ib_prio[port*P +: P]  = P'(prio);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; ib_pck = '0; ib_pa = '0; ib_mask = '0; ib_prio = '0; ob_ack = '0;
        model_reset();
        @(negedge clk);
        do_reset();
        check_eq("reset_valid", 32'(ob_valid), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);

        // Single request, two outputs accept together
        post(3, 'h2A, 'h006, 2);
        step();
        check_eq("t1_early_valid", 32'(ob_valid), 32'h0);
        step();
        check_eq("t1_valid", 32'(ob_valid), 32'h006);
        check_eq("t1_pa", 32'(ob_pa), 32'h2A);
        check_eq("t1_prio", 32'(ob_prio), 32'h2);
        ob_ack = 11'h006;
        step();
        check_eq("t1_ack", 32'(ib_ack), 32'h008);
        step();
        check_eq("t1_ack_once", 32'(ib_ack), 32'h0);

        // Two simultaneous requests, then wrap of the round-robin pointer
        do_reset();
        post(0, 'h100, 'h001, 1);
        post(5, 'h155, 'h001, 5);
        step(); step();
        check_eq("t2_first_pa", 32'(ob_pa), 32'h100);
        ob_ack = 11'h001;
        step();
        check_eq("t2_first_ack", 32'(ib_ack), 32'h001);
        step(); step();
        check_eq("t2_second_pa", 32'(ob_pa), 32'h155);
        ob_ack = 11'h001;
        step();
        check_eq("t2_second_ack", 32'(ib_ack), 32'h020);
        step();
        post(0, 'h101, 'h001, 1);
        post(5, 'h156, 'h001, 5);
        step(); step();
        check_eq("t2_wrap_pa", 32'(ob_pa), 32'h101);
        ob_ack = 11'h001;
        step();
        check_eq("t2_wrap_ack", 32'(ib_ack), 32'h001);
        step(); step();
        ob_ack = 11'h001;
        step(); step();

        // Full broadcast, outputs accept one at a time from the top
        do_reset();
        post(4, 'h3C1, 'h7FF, 7);
        step(); step();
        check_eq("t3_valid_all", 32'(ob_valid), 32'h7FF);
        for (int j = int'(N) - 1; j >= 0; j--) begin
            ob_ack = N'(1) << j;
            step();
            check_eq("t3_valid_left", 32'(ob_valid), (j == 0) ? 32'h0 : ((32'h1 << j) - 32'h1));
            check_eq("t3_ack", 32'(ib_ack), (j == 0) ? 32'h010 : 32'h0);
        end
        step();
        check_eq("t3_ack_once", 32'(ib_ack), 32'h0);

        // Empty destination mask completes without any offer
        do_reset();
        post(7, 'h011, 'h000, 3);
        step();
        check_eq("t4_no_valid_a", 32'(ob_valid), 32'h0);
        step();
        check_eq("t4_no_valid_b", 32'(ob_valid), 32'h0);
        check_eq("t4_ack", 32'(ib_ack), 32'h080);
        step();

        // Reset while an offer is outstanding
        do_reset();
        post(2, 'h222, 'h010, 4);
        step(); step();
        check_eq("t5_valid", 32'(ob_valid), 32'h010);
        rst = 1'b1;
        step();
        check_eq("t5_rst_valid", 32'(ob_valid), 32'h0);
        check_eq("t5_rst_busy", 32'(busy), 32'h0);
        check_eq("t5_rst_pa", 32'(ob_pa), 32'h0);
        for (int c = 0; c < 4; c++) begin
            ob_ack = 11'h010;
            step();
            check_eq("t5_no_ack", 32'(ib_ack), 32'h0);
        end

        // Overrun while pending and a stray output acknowledge
        do_reset();
        post(1, 'h0AB, 'h010, 6);
        step();
        post(1, 'h3FF, 'h7FF, 1);
        step();
        check_eq("t6_err", 32'(dut.err_overrun_q), 32'h1);
        check_eq("t6_pa_kept", 32'(ob_pa), 32'h0AB);
        ob_ack = 11'h200;
        step();
        check_eq("t6_stray", 32'(ob_valid), 32'h010);
        ob_ack = 11'h010;
        step();
        check_eq("t6_ack", 32'(ib_ack), 32'h002);
        step();

        // Random traffic
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ib_pa   = {$urandom, $urandom, $urandom, $urandom};
            ib_mask = {$urandom, $urandom, $urandom, $urandom};
            ib_prio = {$urandom, $urandom};
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    if ($urandom_range(0, 5) == 0) ib_mask[i*N +: N] = '0;
                    ib_pck[i] = 1'b1;
                end
            end
            ob_ack = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 699) == 0) rst = 1'b1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
